// File: rtl/touch_pkg.sv
// Shared definitions for the touch hit decoder and downstream game logic.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package touch_pkg;

    // Width of a hole index (up to 4x4 holes).
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_CLASSIFY = 2'd2,
        ST_HOLD     = 2'd3
    } state_t;

    // Half-open pixel interval [lo, hi) covered by one cell along one axis.
    // 17 bits so that origin + idx*pitch + cell_w cannot wrap a 16-bit coord.
    typedef struct packed {
        logic [16:0] lo;
        logic [16:0] hi;
    } cell_bounds_t;

    function automatic cell_bounds_t cell_bounds(input int origin,
                                                 input int pitch,
                                                 input int cell_w,
                                                 input int idx);
        cell_bounds_t b;
        b.lo = 17'(origin + idx * pitch);
        b.hi = 17'(origin + idx * pitch + cell_w);
        return b;
    endfunction

endpackage

// File: rtl/touch_cell_lookup.sv
// Maps one coordinate axis onto a cell index (combinational compares, no divider).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows input every cycle.
//
// Ports:
//   coord   : pixel coordinate on this axis
//   in_cell : coordinate lies inside one of the N cells (not in a gap or off-grid)
//   idx     : index of the matching cell, 0 when in_cell is low
module touch_cell_lookup
    import touch_pkg::*;
#(
    parameter int ORIGIN = 40,
    parameter int PITCH  = 240,
    parameter int CELL_W = 200,
    parameter int N      = 3
) (
    input  logic [15:0] coord,
    output logic        in_cell,
    output logic [1:0]  idx
);

    logic [16:0]  w_coord;
    logic [N-1:0] w_match;

    assign w_coord = {1'b0, coord};

    // Cell bounds are elaboration-time constants, so each compare is against
    // a fixed value.
    for (genvar c = 0; c < N; c++) begin : g_cell
        localparam cell_bounds_t B = cell_bounds(ORIGIN, PITCH, CELL_W, c);
        assign w_match[c] = (w_coord >= B.lo) && (w_coord < B.hi);
    end

    // PITCH >= CELL_W keeps cells disjoint, so at most one bit is set.
    always_comb begin
        in_cell = 1'b0;
        idx     = 2'd0;
        for (int c = 0; c < N; c++) begin
            if (w_match[c]) begin
                in_cell = 1'b1;
                idx     = 2'(c);
            end
        end
    end

endmodule

// File: rtl/touch_hit_decoder.sv
// Debounces touch presses and classifies each one as a hit on a mole hole or a miss.
// Latency: valid first sampled in cycle t and stable for DEBOUNCE cycles -> pulse in cycle t+DEBOUNCE+1.
// Backpressure: none; one hit/miss pulse per physical press, no stalling of the touch stream.
//
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   enable           : game active; gates hit/miss pulses in the classify cycle
//   touch_valid      : finger present, tp_x_coord/tp_y_coord valid
//   hit_valid/idx    : one-cycle hit pulse with hole index row*COLS+col
//   miss_valid       : one-cycle pulse for a press outside every hole
//   hit_x/hit_y      : coords of the last accepted press
//   pressed          : press accepted and not yet released
module touch_hit_decoder
    import touch_pkg::*;
#(
    parameter int X0       = 40,
    parameter int Y0       = 100,
    parameter int CELL_W   = 200,
    parameter int PITCH    = 240,
    parameter int COLS     = 3,
    parameter int ROWS     = 3,
    parameter int DEBOUNCE = 4,
    parameter int RELEASE  = 8,
    parameter int JITTER   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             touch_valid,
    input  logic [15:0]      tp_x_coord,
    input  logic [15:0]      tp_y_coord,
    output logic             hit_valid,
    output logic [IDX_W-1:0] hit_idx,
    output logic             miss_valid,
    output logic [15:0]      hit_x,
    output logic [15:0]      hit_y,
    output logic             pressed
);

    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam int RL_W = $clog2(RELEASE + 1);

    state_t           r_state;
    logic [DB_W-1:0]  r_cnt;
    logic [RL_W-1:0]  r_rel_cnt;
    logic [15:0]      r_ref_x;
    logic [15:0]      r_ref_y;
    logic             r_hit_valid;
    logic             r_miss_valid;
    logic [IDX_W-1:0] r_hit_idx;
    logic [15:0]      r_hit_x;
    logic [15:0]      r_hit_y;
    logic             r_pressed;

    logic [16:0]      w_x17, w_y17, w_rx17, w_ry17;
    logic [16:0]      w_dx, w_dy;
    logic             w_far;
    logic [DB_W-1:0]  w_cnt_nxt;
    logic [RL_W-1:0]  w_rel_nxt;
    logic             w_col_in, w_row_in;
    logic [1:0]       w_col, w_row;
    logic [IDX_W-1:0] w_idx;

    // Absolute per-axis deviation from the reference point, 17-bit unsigned.
    assign w_x17  = {1'b0, tp_x_coord};
    assign w_y17  = {1'b0, tp_y_coord};
    assign w_rx17 = {1'b0, r_ref_x};
    assign w_ry17 = {1'b0, r_ref_y};
    assign w_dx   = (w_x17 >= w_rx17) ? (w_x17 - w_rx17) : (w_rx17 - w_x17);
    assign w_dy   = (w_y17 >= w_ry17) ? (w_y17 - w_ry17) : (w_ry17 - w_y17);
    // A deviation exactly equal to JITTER is still in tolerance.
    assign w_far  = (w_dx > 17'(JITTER)) || (w_dy > 17'(JITTER));

    assign w_cnt_nxt = r_cnt + DB_W'(1);
    assign w_rel_nxt = r_rel_cnt + RL_W'(1);

    // Classification always works on the debounced reference point.
    touch_cell_lookup #(
        .ORIGIN (X0),
        .PITCH  (PITCH),
        .CELL_W (CELL_W),
        .N      (COLS)
    ) u_col_lookup (
        .coord   (r_ref_x),
        .in_cell (w_col_in),
        .idx     (w_col)
    );

    touch_cell_lookup #(
        .ORIGIN (Y0),
        .PITCH  (PITCH),
        .CELL_W (CELL_W),
        .N      (ROWS)
    ) u_row_lookup (
        .coord   (r_ref_y),
        .in_cell (w_row_in),
        .idx     (w_row)
    );

    assign w_idx = IDX_W'(w_row) * IDX_W'(COLS) + IDX_W'(w_col);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_rel_cnt    <= '0;
            r_ref_x      <= '0;
            r_ref_y      <= '0;
            r_hit_valid  <= 1'b0;
            r_miss_valid <= 1'b0;
            r_hit_idx    <= '0;
            r_hit_x      <= '0;
            r_hit_y      <= '0;
            r_pressed    <= 1'b0;
        end else begin
            // Pulses are single-cycle unless re-raised below.
            r_hit_valid  <= 1'b0;
            r_miss_valid <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (touch_valid) begin
                        r_ref_x <= tp_x_coord;
                        r_ref_y <= tp_y_coord;
                        r_cnt   <= DB_W'(1);
                        r_state <= (DEBOUNCE == 1) ? ST_CLASSIFY : ST_DEBOUNCE;
                    end
                end

                ST_DEBOUNCE: begin
                    if (!touch_valid) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else if (w_far) begin
                        // Finger moved too far: restart debounce at the new point.
                        r_ref_x <= tp_x_coord;
                        r_ref_y <= tp_y_coord;
                        r_cnt   <= DB_W'(1);
                    end else begin
                        r_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt == DB_W'(DEBOUNCE)) begin
                            r_state <= ST_CLASSIFY;
                        end
                    end
                end

                ST_CLASSIFY: begin
                    // With enable low the press is still consumed, just not reported.
                    if (enable) begin
                        r_hit_x <= r_ref_x;
                        r_hit_y <= r_ref_y;
                        if (w_col_in && w_row_in) begin
                            r_hit_valid <= 1'b1;
                            r_hit_idx   <= w_idx;
                        end else begin
                            r_miss_valid <= 1'b1;
                        end
                    end
                    r_pressed <= 1'b1;
                    r_cnt     <= '0;
                    r_rel_cnt <= '0;
                    r_state   <= ST_HOLD;
                end

                ST_HOLD: begin
                    // Only a full run of RELEASE invalid cycles ends the press;
                    // sliding or bouncing while held never re-triggers.
                    if (touch_valid) begin
                        r_rel_cnt <= '0;
                    end else if (w_rel_nxt == RL_W'(RELEASE)) begin
                        r_rel_cnt <= '0;
                        r_pressed <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_rel_cnt <= w_rel_nxt;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign hit_valid  = r_hit_valid;
    assign miss_valid = r_miss_valid;
    assign hit_idx    = r_hit_idx;
    assign hit_x      = r_hit_x;
    assign hit_y      = r_hit_y;
    assign pressed    = r_pressed;

endmodule

// File: tb/tb_touch_hit_decoder.sv
// Directed, table-driven bench for touch_hit_decoder with default parameters.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_touch_hit_decoder;
    import touch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        touch_valid;
    logic [15:0] tp_x_coord;
    logic [15:0] tp_y_coord;
    logic        hit_valid;
    logic [3:0]  hit_idx;
    logic        miss_valid;
    logic [15:0] hit_x;
    logic [15:0] hit_y;
    logic        pressed;

    touch_hit_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .touch_valid (touch_valid),
        .tp_x_coord  (tp_x_coord),
        .tp_y_coord  (tp_y_coord),
        .hit_valid   (hit_valid),
        .hit_idx     (hit_idx),
        .miss_valid  (miss_valid),
        .hit_x       (hit_x),
        .hit_y       (hit_y),
        .pressed     (pressed)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle stimulus record for the sequence runner.
    typedef struct packed {
        logic        rst;
        logic        en;
        logic        v;
        logic [15:0] x;
        logic [15:0] y;
    } drv_t;

    drv_t seq[$];

    // Results of the most recent run_seq call.
    int          n_hit, n_miss, n_both, first_pulse;
    logic [3:0]  p_idx;
    logic [15:0] p_x, p_y;
    logic        pr_trace [0:63];
    logic [15:0] hx_trace [0:63];
    logic [15:0] hy_trace [0:63];

    task automatic push(input logic r, input logic e, input logic v,
                        input logic [15:0] x, input logic [15:0] y, input int n);
        drv_t d;
        d.rst = r; d.en = e; d.v = v; d.x = x; d.y = y;
        repeat (n) seq.push_back(d);
    endtask

    // Inputs for cycle c are driven 1ns after an edge; outputs observed 1ns
    // after the next edge are recorded as cycle c+1.
    task automatic run_seq(input int ncyc);
        drv_t d;
        n_hit = 0; n_miss = 0; n_both = 0; first_pulse = -1;
        p_idx = '0; p_x = '0; p_y = '0;
        for (int c = 0; c < ncyc; c++) begin
            if (c < seq.size()) d = seq[c];
            else begin
                d.rst = 1'b0; d.en = 1'b1; d.v = 1'b0; d.x = '0; d.y = '0;
            end
            rst         = d.rst;
            enable      = d.en;
            touch_valid = d.v;
            tp_x_coord  = d.x;
            tp_y_coord  = d.y;
            @(posedge clk);
            #1;
            if (c + 1 < 64) begin
                pr_trace[c+1] = pressed;
                hx_trace[c+1] = hit_x;
                hy_trace[c+1] = hit_y;
            end
            if (hit_valid && miss_valid) n_both++;
            if (hit_valid)  n_hit++;
            if (miss_valid) n_miss++;
            if ((hit_valid || miss_valid) && first_pulse < 0) begin
                first_pulse = c + 1;
                p_idx = hit_idx;
                p_x   = hit_x;
                p_y   = hit_y;
            end
        end
        seq.delete();
    endtask

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        en;
        logic        exp_hit;
        logic        exp_miss;
        logic [3:0]  exp_idx;
    } vec_t;

    vec_t vecs[14];

    initial begin
        // x, y, en, hit, miss, idx  (cols 40..239/280..479/520..719, rows 100..299/340..539/580..779)
        vecs[0]  = '{16'd300,   16'd400,   1'b1, 1'b1, 1'b0, 4'd4};
        vecs[1]  = '{16'd250,   16'd150,   1'b1, 1'b0, 1'b1, 4'd0};
        vecs[2]  = '{16'd100,   16'd150,   1'b1, 1'b1, 1'b0, 4'd0};
        vecs[3]  = '{16'd600,   16'd650,   1'b1, 1'b1, 1'b0, 4'd8};
        vecs[4]  = '{16'd40,    16'd100,   1'b1, 1'b1, 1'b0, 4'd0};
        vecs[5]  = '{16'd239,   16'd299,   1'b1, 1'b1, 1'b0, 4'd0};
        vecs[6]  = '{16'd240,   16'd100,   1'b1, 1'b0, 1'b1, 4'd0};
        vecs[7]  = '{16'd280,   16'd340,   1'b1, 1'b1, 1'b0, 4'd4};
        vecs[8]  = '{16'd719,   16'd779,   1'b1, 1'b1, 1'b0, 4'd8};
        vecs[9]  = '{16'd720,   16'd600,   1'b1, 1'b0, 1'b1, 4'd0};
        vecs[10] = '{16'd0,     16'd0,     1'b1, 1'b0, 1'b1, 4'd0};
        vecs[11] = '{16'd65535, 16'd65535, 1'b1, 1'b0, 1'b1, 4'd0};
        vecs[12] = '{16'd40,    16'd580,   1'b1, 1'b1, 1'b0, 4'd6};
        vecs[13] = '{16'd520,   16'd100,   1'b1, 1'b1, 1'b0, 4'd2};

        rst = 1'b1; enable = 1'b1; touch_valid = 1'b0;
        tp_x_coord = '0; tp_y_coord = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset hit_valid",  32'(hit_valid),  0);
        check("reset miss_valid", 32'(miss_valid), 0);
        check("reset hit_idx",    32'(hit_idx),    0);
        check("reset hit_x",      32'(hit_x),      0);
        check("reset hit_y",      32'(hit_y),      0);
        check("reset pressed",    32'(pressed),    0);
        rst = 1'b0;

        // Clean 4-cycle presses: pulse in cycle 5, release complete at cycle 13.
        for (int i = 0; i < 14; i++) begin
            push(1'b0, vecs[i].en, 1'b1, vecs[i].x, vecs[i].y, 4);
            run_seq(20);
            check($sformatf("vec%0d hit count", i),  n_hit,  32'(vecs[i].exp_hit));
            check($sformatf("vec%0d miss count", i), n_miss, 32'(vecs[i].exp_miss));
            check($sformatf("vec%0d exclusive", i),  n_both, 0);
            if (vecs[i].exp_hit || vecs[i].exp_miss) begin
                check($sformatf("vec%0d latency", i), first_pulse, 5);
                check($sformatf("vec%0d hit_x", i),   32'(p_x), 32'(vecs[i].x));
                check($sformatf("vec%0d hit_y", i),   32'(p_y), 32'(vecs[i].y));
            end
            if (vecs[i].exp_hit)
                check($sformatf("vec%0d hit_idx", i), 32'(p_idx), 32'(vecs[i].exp_idx));
            check($sformatf("vec%0d pressed@5", i),  32'(pr_trace[5]),  1);
            check($sformatf("vec%0d pressed@12", i), 32'(pr_trace[12]), 1);
            check($sformatf("vec%0d pressed@13", i), 32'(pr_trace[13]), 0);
        end

        // enable low for the whole press: consumed silently, pressed still rises.
        push(1'b0, 1'b0, 1'b1, 16'd300, 16'd400, 4);
        push(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16);
        run_seq(20);
        check("disabled pulses",   n_hit + n_miss, 0);
        check("disabled pressed",  32'(pr_trace[5]),  1);
        check("disabled released", 32'(pr_trace[13]), 0);

        // Bounce: 3 valid, 1 low, then 4 stable -> one hit, timed from the restart.
        push(1'b0, 1'b1, 1'b1, 16'd100, 16'd150, 3);
        push(1'b0, 1'b1, 1'b0, 16'd100, 16'd150, 1);
        push(1'b0, 1'b1, 1'b1, 16'd100, 16'd150, 4);
        run_seq(30);
        check("bounce hits",    n_hit, 1);
        check("bounce misses",  n_miss, 0);
        check("bounce latency", first_pulse, 9);
        check("bounce idx",     32'(p_idx), 0);

        // Jump beyond jitter on cycle 1 relatches the reference.
        push(1'b0, 1'b1, 1'b1, 16'd100, 16'd150, 1);
        push(1'b0, 1'b1, 1'b1, 16'd600, 16'd650, 4);
        run_seq(30);
        check("jump hits",    n_hit + n_miss, 1);
        check("jump latency", first_pulse, 6);
        check("jump idx",     32'(p_idx), 8);
        check("jump hit_x",   32'(p_x), 600);
        check("jump hit_y",   32'(p_y), 650);

        // Deviation exactly JITTER on both axes stays with the first point.
        push(1'b0, 1'b1, 1'b1, 16'd300, 16'd400, 1);
        push(1'b0, 1'b1, 1'b1, 16'd308, 16'd392, 3);
        run_seq(30);
        check("jitter8 latency", first_pulse, 5);
        check("jitter8 hit_x",   32'(p_x), 300);
        check("jitter8 hit_y",   32'(p_y), 400);

        // Deviation JITTER+1 restarts debounce.
        push(1'b0, 1'b1, 1'b1, 16'd300, 16'd400, 1);
        push(1'b0, 1'b1, 1'b1, 16'd309, 16'd400, 4);
        run_seq(30);
        check("jitter9 latency", first_pulse, 6);
        check("jitter9 hit_x",   32'(p_x), 309);

        // Held press, short lift, slide to another hole, then release.
        push(1'b0, 1'b1, 1'b1, 16'd300, 16'd400, 4);
        push(1'b0, 1'b1, 1'b0, 16'd0,   16'd0,   7);
        push(1'b0, 1'b1, 1'b1, 16'd600, 16'd650, 5);
        push(1'b0, 1'b1, 1'b0, 16'd0,   16'd0,   8);
        run_seq(30);
        check("slide pulses",     n_hit + n_miss, 1);
        check("slide idx",        32'(p_idx), 4);
        check("slide pressed@15", 32'(pr_trace[15]), 1);
        check("slide pressed@23", 32'(pr_trace[23]), 1);
        check("slide pressed@24", 32'(pr_trace[24]), 0);

        // enable low during debounce, high at classify: hit is reported.
        push(1'b0, 1'b0, 1'b1, 16'd300, 16'd400, 3);
        push(1'b0, 1'b1, 1'b1, 16'd300, 16'd400, 1);
        run_seq(20);
        check("en-late hits",    n_hit, 1);
        check("en-late latency", first_pulse, 5);

        // enable high during debounce, low at classify: no pulse.
        push(1'b0, 1'b1, 1'b1, 16'd300, 16'd400, 4);
        push(1'b0, 1'b0, 1'b0, 16'd0,   16'd0,   1);
        run_seq(20);
        check("en-drop pulses",  n_hit + n_miss, 0);
        check("en-drop pressed", 32'(pr_trace[5]), 1);

        // Reset in DEBOUNCE: outputs cleared next cycle, FSM back in IDLE.
        push(1'b0, 1'b1, 1'b1, 16'd300, 16'd400, 2);
        push(1'b1, 1'b1, 1'b1, 16'd300, 16'd400, 1);
        push(1'b0, 1'b1, 1'b1, 16'd300, 16'd400, 5);
        run_seq(30);
        check("rst hit_x@3",   32'(hx_trace[3]), 0);
        check("rst hit_y@3",   32'(hy_trace[3]), 0);
        check("rst pressed@3", 32'(pr_trace[3]), 0);
        check("rst restart latency", first_pulse, 8);
        check("rst restart hits",    n_hit, 1);

        // Reset in CLASSIFY suppresses the pending pulse.
        push(1'b0, 1'b1, 1'b1, 16'd300, 16'd400, 4);
        push(1'b1, 1'b1, 1'b0, 16'd0,   16'd0,   1);
        run_seq(20);
        check("rst-classify pulses",  n_hit + n_miss, 0);
        check("rst-classify pressed", 32'(pr_trace[5]), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
